// File: rtl/w_74hc191.sv
// w_74hc191: synchronous presettable up/down binary counter in the style of
// the 74HC191. The load is synchronous and TC/RC_N are purely combinational
// from the count, so the whole block runs on CP. The only exception is the
// asynchronous master clear.
module w_74hc191 #(
    parameter int WIDTH = 4
) (
    input  logic             CP,
    input  logic             MR_N,
    input  logic             CE_N,
    input  logic             U_D,
    input  logic             PL_N,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             RC_N
);

    // Sized increment/decrement step, so the add and subtract stay at WIDTH bits.
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load has priority over counting, and counting has priority over hold.
    always_comb begin
        count_d = count_q;
        if (!PL_N) begin
            count_d = D;
        end else if (!CE_N) begin
            if (U_D) begin
                count_d = count_q - ONE;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // Count register with an asynchronous clear from the master reset.
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Q = count_q;

    // The terminal count depends only on the state and the direction.
    // This lets a direction change show up on TC immediately.
    assign TC   = U_D ? (count_q == '0) : (count_q == '1);

    // The ripple carry/borrow is gated only by the enable and never by CP.
    // This keeps the cascade chain free of clock glitches.
    assign RC_N = ~(TC & ~CE_N);

endmodule

// File: doc/w_74hc191.md
Name: w_74hc191

Overview:
- Synchronous presettable 4-bit up/down binary counter, modelled on the 74HC191 function set.
- Adds the down-counting direction to the lab's counter family, so the team's up-count-only parts can be checked against, or cascaded with, a reversible counter.
- Intended for the EDA sequential-circuit experiments: down-timers, reversible position counters, and cascaded multi-digit counters.
- Load is synchronous and ripple-carry outputs are clock-free (deviations from the TTL part), so the whole block is single-clock.

Parameters:
- WIDTH, 4, counter width in bits; must be ≥ 2. Test plan values assume 4.

Ports:
- CP, input, 1, counter clock; all state changes occur on its rising edge.
- MR_N, input, 1, master reset, asynchronous, active-low. Clears Q immediately.
- CE_N, input, 1, count enable, active-low.
- U_D, input, 1, direction select: 0 = count up, 1 = count down.
- PL_N, input, 1, parallel load, active-low, synchronous.
- D, input, WIDTH, parallel load data.
- Q, output, WIDTH, counter state (registered).
- TC, output, 1, terminal count, active-high (combinational from Q and U_D).
- RC_N, output, 1, ripple carry/borrow for cascading, active-low (combinational).

Behaviour:
- Reset:
  - MR_N=0 forces Q=0 asynchronously, with no CP edge required, and holds it while low.
  - Output values during reset: TC = U_D ? 1 : 0; RC_N = ~(TC & ~CE_N).
  - Deassertion is asynchronous; the first count or load happens on the first CP rise with MR_N=1.
- Priority on each CP rising edge with MR_N=1: PL_N > CE_N > hold.
  - PL_N=0: Q <= D. CE_N and U_D are ignored.
  - PL_N=1, CE_N=0, U_D=0: Q <= Q+1 mod 2^WIDTH. All-ones wraps to 0.
  - PL_N=1, CE_N=0, U_D=1: Q <= Q-1 mod 2^WIDTH. 0 wraps to all-ones.
  - PL_N=1, CE_N=1: Q holds.
- Latency: Q reflects a load or count one cycle after the sampling edge, i.e. visible after that edge.
- TC:
  - TC = (U_D=0 & Q=all-ones) | (U_D=1 & Q=0).
  - Independent of CE_N and PL_N.
  - Changes immediately with U_D; no clock needed.
- RC_N:
  - RC_N = ~(TC & ~CE_N).
  - Drives CE_N of the next stage in a synchronous cascade. All stages share CP, U_D and PL_N.
  - RC_N never depends on CP, so there are no clock-gated glitches.
- Direction change: U_D may change at any cycle. The next enabled edge uses the new direction, with no extra latency or dead cycle.
- Simultaneous events:
  - PL_N=0 and CE_N=0 on the same edge: load wins.
  - MR_N=0 at any time, including mid-count or on a load edge: Q=0 wins.
- Boundary: loading D=all-ones with U_D=0, or D=0 with U_D=1, makes TC=1 on the cycle after the load.
- No X propagation: all registers are reset by MR_N. Outputs are defined whenever MR_N has been asserted once.

Test Plan:
1. MR_N=0 pulse mid-cycle with Q=0xA and U_D=0 -> Q=0x0 immediately, before any CP edge; TC=0; RC_N=1.
2. PL_N=0, D=0x5, CE_N=0, one edge -> Q=0x5. Then PL_N=1, U_D=0, CE_N=0 for 3 edges -> Q=0x6, 0x7, 0x8.
3. Up wrap: load 0xE, U_D=0, CE_N=0:
   - Q=0xE: TC=0.
   - Q=0xF: TC=1, RC_N=0.
   - Next edge: Q=0x0, TC=0.
   - With CE_N=1 at Q=0xF: TC=1, RC_N=1, and Q holds 0xF.
4. Down wrap: load 0x1, U_D=1, CE_N=0:
   - Q=0x1: TC=0.
   - Q=0x0: TC=1, RC_N=0.
   - Next edge: Q=0xF.
   - With Q=0x0, toggling U_D to 0 makes TC=0 combinationally.
5. Direction change at Q=0x7: U_D switches 0->1 between edges with CE_N=0 -> Q sequence 0x7, 0x6, 0x5, with no hold cycle.
6. Cascade two instances (low RC_N -> high CE_N), U_D=0, from 0x0F:
   - Next edge: 8-bit value 0x10.
   - Counting down from 0x10: next edge gives 0x0F.
   - At 0xFF up: both TC=1; next edge gives 0x00.
